program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer-side counterpart to the CPU instruction fetch path: it fills instruction RAM before the CPU runs.
- Receives a byte stream with a valid/ready handshake.
- Reads a 16-bit word-count header, then assembles 32-bit instruction words (MSB byte first) and writes them to consecutive RAM addresses from BASE_ADDR.
- Holds the CPU in reset (cpu_reset_n low) until the load completes, then releases it.

Parameters:
BASE_ADDR, 16'h0000, RAM address of first instruction word (CPU PC reset value)
MAX_WORDS, 16'd1024, largest legal word count; larger header flags error
WRITE_HOLD, 2, cycles mem_enable/write held per word (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse, begin a load
byte_in  in  8  stream data byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  loader accepts byte this cycle
mem_enable  out  1  RAM enable
mem_read_write  out  1  RAM direction; 0 = write, 1 = read (loader only writes)
mem_address  out  16  RAM word address
mem_data_in  out  32  write data to RAM
busy  out  1  load in progress
done  out  1  load finished (success or error)
error  out  1  header count > MAX_WORDS
cpu_reset_n  out  1  CPU reset, active-low; high only in DONE with error=0
words_written  out  16  count of words committed to RAM

Behaviour:
- Reset (reset==0 at posedge clk):
  - State goes to IDLE.
  - All outputs 0, except mem_read_write=1.
  - cpu_reset_n=0.
  - Internal count, byte index and word index cleared.
  - Reset mid-load aborts the load immediately; no further RAM writes.
- Byte transfer: a byte transfers on a posedge where byte_valid && byte_ready. byte_ready is a registered function of state: 1 in HDR_HI, HDR_LO and COLLECT; 0 in all other states.
- States and transitions:
  - IDLE: start -> HDR_HI, busy=1.
  - HDR_HI: on transfer, count[15:8]=byte_in -> HDR_LO.
  - HDR_LO: on transfer, count[7:0]=byte_in.
    - Full count==0 -> DONE, error=0, no writes.
    - count>MAX_WORDS -> DONE, error=1.
    - Otherwise -> COLLECT.
  - COLLECT: shift in bytes MSB first (first byte -> word[31:24]). After the 4th transfer -> WRITE on the next cycle.
  - WRITE: held for exactly WRITE_HOLD cycles with:
    - mem_enable=1, mem_read_write=0
    - mem_address=BASE_ADDR+word index
    - mem_data_in=assembled word
    
    On the last cycle, words_written and word index increment. Then go to DONE if the new index==count, else COLLECT.
  - DONE: done=1, busy=0. cpu_reset_n=~error. start -> HDR_HI, with done, error and words_written cleared and cpu_reset_n=0 in the same cycle.
- Output values outside WRITE: mem_enable=0, mem_read_write=1, mem_data_in holds the last value.
- Address arithmetic: BASE_ADDR+index computed modulo 2^16; wrap past 16'hFFFF is allowed and not flagged.
- start handling: ignored in HDR_HI, HDR_LO, COLLECT and WRITE.
- Stalls: byte_valid low stalls indefinitely with no timeout.
- Bytes offered while byte_ready=0 are not consumed (source must hold them).
- Latency:
  - 4th byte accepted at edge N -> mem_enable high from edge N+1 through edge N+WRITE_HOLD.
  - For the final word, done=1 after edge N+WRITE_HOLD+1.
- Throughput: one word per 4+WRITE_HOLD cycles with byte_valid held high.

Test Plan:
- Reset, start, stream 00 01 E1 23 45 67 with valid held high -> one write.
  - addr 0x0000, data 0xE1234567, mem_enable high for 2 cycles.
  - words_written=1, done=1, cpu_reset_n=1, error=0.
- Header 00 03, then words 0x11111111, 0x22222222, 0x33333333 with byte_valid toggling every other cycle -> writes at addr 0,1,2 with correct data; no byte lost or duplicated; words_written=3.
- Header 04 01 (1025 > MAX_WORDS) -> no mem_enable pulse, done=1, error=1, cpu_reset_n stays 0.
- Header 00 00 -> done=1, error=0, cpu_reset_n=1, words_written=0, no writes.
- Mid-load reset: reset low after 2 bytes of the second word -> next cycle state IDLE, all outputs at reset values. A following start with header 00 01 and one word writes addr 0x0000.
- BASE_ADDR=16'hFFFF, header 00 02 -> writes at 0xFFFF then 0x0000. start pulsed during COLLECT has no effect. start pulsed in DONE restarts the load with cpu_reset_n driven low in the same cycle.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: reads a 16-bit word count, packs bytes MSB-first into
// 32-bit words, writes them to instruction RAM and holds the CPU in reset until done.
module program_loader #(
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter logic [15:0] MAX_WORDS  = 16'd1024,
  parameter int unsigned WRITE_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_enable,
  output logic        mem_read_write,
  output logic [15:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_reset_n,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_COLLECT, S_WRITE, S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(WRITE_HOLD - 1);

  state_t      state_q;
  logic [15:0] count_q, widx_q, ww_q, addr_q;
  logic [1:0]  bidx_q;
  logic [23:0] shift_q;
  logic [31:0] data_q;
  logic [3:0]  hold_q;
  logic        ready_q, me_q, rw_q, busy_q, done_q, err_q, cpu_q;

  logic        xfer;
  logic [15:0] count_full;
  logic [15:0] widx_inc;

  assign xfer       = byte_valid && ready_q;
  assign count_full = {count_q[15:8], byte_in};
  assign widx_inc   = widx_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      widx_q  <= '0;
      ww_q    <= '0;
      addr_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      ready_q <= 1'b0;
      me_q    <= 1'b0;
      rw_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cpu_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_HDR_HI;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            count_q[15:8] <= byte_in;
            state_q       <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            count_q <= count_full;
            bidx_q  <= '0;
            widx_q  <= '0;
            if (count_full == 16'd0) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cpu_q   <= 1'b1;
            end else if (count_full > MAX_WORDS) begin
              state_q <= S_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (xfer) begin
            shift_q <= {shift_q[15:0], byte_in};
            bidx_q  <= bidx_q + 2'd1;
            // The fourth byte completes the word: launch the write directly.
            if (bidx_q == 2'd3) begin
              state_q <= S_WRITE;
              ready_q <= 1'b0;
              me_q    <= 1'b1;
              rw_q    <= 1'b0;
              addr_q  <= BASE_ADDR + widx_q;
              data_q  <= {shift_q, byte_in};
              hold_q  <= '0;
            end
          end
        end
        S_WRITE: begin
          if (hold_q == HOLD_LAST) begin
            me_q   <= 1'b0;
            rw_q   <= 1'b1;
            widx_q <= widx_inc;
            ww_q   <= ww_q + 16'd1;
            if (widx_inc == count_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cpu_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              ready_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q <= S_HDR_HI;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cpu_q   <= 1'b0;
            ww_q    <= '0;
            widx_q  <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready     = ready_q;
  assign mem_enable     = me_q;
  assign mem_read_write = rw_q;
  assign mem_address    = addr_q;
  assign mem_data_in    = data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = err_q;
  assign cpu_reset_n    = cpu_q;
  assign words_written  = ww_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (BASE_ADDR 0x0000 and 0xFFFF) share one
// byte stream; observed RAM writes are compared against a word-list reference.
module tb_program_loader;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    int          h;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic [1:0]  br, me, rw, busy, dn, ef, cpu;
  logic [15:0] ma [2];
  logic [31:0] md [2];
  logic [15:0] ww [2];

  wr_t         wq [2][$];
  int          rwbad [2];
  bit          pm [2];
  logic [31:0] exp_words [16];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16'd1024), .WRITE_HOLD(2)) dut0 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br[0]), .mem_enable(me[0]), .mem_read_write(rw[0]), .mem_address(ma[0]),
    .mem_data_in(md[0]), .busy(busy[0]), .done(dn[0]), .error(ef[0]),
    .cpu_reset_n(cpu[0]), .words_written(ww[0])
  );

  program_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(16'd1024), .WRITE_HOLD(2)) dut1 (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(br[1]), .mem_enable(me[1]), .mem_read_write(rw[1]), .mem_address(ma[1]),
    .mem_data_in(md[1]), .busy(busy[1]), .done(dn[1]), .error(ef[1]),
    .cpu_reset_n(cpu[1]), .words_written(ww[1])
  );

  // Write monitor: one record per mem_enable pulse, with its length in cycles.
  initial begin
    rwbad[0] = 0;
    rwbad[1] = 0;
    pm[0] = 1'b0;
    pm[1] = 1'b0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset === 1'b1) begin
        if ((me[i] === 1'b1 && rw[i] !== 1'b0) || (me[i] === 1'b0 && rw[i] !== 1'b1))
          rwbad[i]++;
        if (me[i] === 1'b1) begin
          if (!pm[i]) begin
            wq[i].push_back('{ma[i], md[i], 1});
          end else begin
            wr_t t;
            t = wq[i].pop_back();
            t.h++;
            wq[i].push_back(t);
          end
          pm[i] = 1'b1;
        end else begin
          pm[i] = 1'b0;
        end
      end else begin
        pm[i] = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ctl%0d", tag, i),
          {60'd0, me[i], rw[i], busy[i], dn[i], ef[i], cpu[i], br[i]}, 64'b0100000);
      chk($sformatf("%s_addr%0d", tag, i), {48'd0, ma[i]}, 64'd0);
      chk($sformatf("%s_data%0d", tag, i), {32'd0, md[i]}, 64'd0);
      chk($sformatf("%s_ww%0d", tag, i), {48'd0, ww[i]}, 64'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit inj);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    if (inj) start = 1'b1;
    t = 0;
    while (br[0] !== 1'b1 && t < 100) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 100) chk("ready_timeout", 64'(t), 64'd0);
    @(negedge clk);
    start = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Reference: a legal count N yields writes base+k / word k for k<N, two cycles each.
  task automatic check_result(input string tag, input int cnt);
    int          nexp;
    bit          bad;
    logic [15:0] base;
    wr_t         w;
    bad  = (cnt > 1024);
    nexp = bad ? 0 : cnt;
    for (int i = 0; i < 2; i++) begin
      base = (i == 0) ? 16'h0000 : 16'hFFFF;
      chk($sformatf("%s_nwr%0d", tag, i), 64'(wq[i].size()), 64'(nexp));
      chk($sformatf("%s_ww%0d", tag, i), {48'd0, ww[i]}, 64'(nexp));
      chk($sformatf("%s_stat%0d", tag, i), {60'd0, dn[i], busy[i], ef[i], cpu[i]},
          {60'd0, 1'b1, 1'b0, bad, !bad});
      chk($sformatf("%s_rw%0d", tag, i), 64'(rwbad[i]), 64'd0);
      for (int k = 0; k < wq[i].size() && k < nexp; k++) begin
        w = wq[i][k];
        chk($sformatf("%s_a%0d_%0d", tag, i, k), {48'd0, w.a}, {48'd0, 16'(base + 16'(k))});
        chk($sformatf("%s_d%0d_%0d", tag, i, k), {32'd0, w.d}, {32'd0, exp_words[k]});
        chk($sformatf("%s_h%0d_%0d", tag, i, k), 64'(w.h), 64'd2);
      end
    end
  endtask

  task automatic do_load(input string tag, input int cnt, input int mode,
                         input bit pulse, input int inj_at);
    logic [15:0] c;
    logic [31:0] w;
    int          g;
    int          t;
    c = 16'(cnt);
    wq[0].delete();
    wq[1].delete();
    if (pulse) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    send_byte(c[15:8], 0, 1'b0);
    send_byte(c[7:0], 0, 1'b0);
    if (cnt >= 1 && cnt <= 1024) begin
      for (int k = 0; k < cnt; k++) begin
        w = exp_words[k];
        for (int j = 0; j < 4; j++) begin
          g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
          send_byte(w[31-8*j -: 8], g, (4*k + j) == inj_at);
        end
      end
    end
    t = 0;
    while (dn[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk({tag, "_done_timeout"}, 64'(t), 64'd0);
    repeat (2) @(negedge clk);
    check_result(tag, cnt);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b1;
    @(negedge clk);

    exp_words[0] = 32'hE1234567;
    do_load("one", 1, 0, 1'b1, -1);

    // Restart from DONE: CPU goes back into reset on the start edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("restart%0d", i), {59'd0, cpu[i], dn[i], busy[i], ef[i], br[i]},
          {59'd0, 5'b00101});
    chk("restart_ww", {48'd0, ww[0]}, 64'd0);
    exp_words[0] = 32'h11111111;
    exp_words[1] = 32'h22222222;
    exp_words[2] = 32'h33333333;
    do_load("three", 3, 1, 1'b0, -1);

    do_load("toobig", 1025, 0, 1'b1, -1);
    do_load("zero", 0, 0, 1'b1, -1);

    exp_words[0] = $urandom;
    exp_words[1] = $urandom;
    do_load("wrap_startcol", 2, 2, 1'b1, 1);

    // Mid-load reset after two bytes of the second word.
    wq[0].delete();
    wq[1].delete();
    exp_words[0] = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(exp_words[0][31-8*j -: 8], 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    send_byte(8'hCD, 0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_nwr", 64'(wq[0].size()), 64'd1);
    exp_words[0] = $urandom;
    do_load("after_rst", 1, 0, 1'b1, -1);

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) exp_words[k] = $urandom;
      do_load($sformatf("rand%0d", r), n, 2, 1'b1, int'($urandom_range(1, 4*n - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
